// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
//
// Parallel-in / serial-out transmitter. When start is accepted in IDLE, an N-bit
// word is captured and shifted out LSB-first, one bit per clock. Status outputs
// (busy / ready / done) let a controller stream words back-to-back with a single
// IDLE cycle between frames. A right-shifting receiver that shifts on clk while
// s_valid is high ends up holding the original word.
//
// Optional feature (compile-time macro PIPO_TX_PARITY_EN):
//   When defined, an extra PAR cycle follows the last data bit and carries the
//   even parity (XOR) of the captured word. done then moves to the PAR cycle and
//   the frame becomes N+1 cycles long. When undefined, no parity logic exists.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   start    in   transmit request, sampled only while ready = 1
//   din      in   [N-1:0] parallel word, captured on the accepting edge only
//   s_out    out  serial data, LSB first; 0 when no frame bit is on the line
//   s_valid  out  high in every cycle that s_out carries a frame bit
//   busy     out  high from the cycle after acceptance through the last bit
//   ready    out  high in IDLE (always ~busy)
//   done     out  one-cycle pulse coincident with the last frame bit
//
// All outputs are decoded from registered state only; start and din have no
// combinational path to any output.
// -----------------------------------------------------------------------------
module piso_shift_tx #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] din,
    output logic         s_out,
    output logic         s_valid,
    output logic         busy,
    output logic         ready,
    output logic         done
);

    localparam int             CW   = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

`ifdef PIPO_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t        state, state_next;
    logic [N-1:0]  sh_reg, sh_next;
    logic [CW-1:0] cnt, cnt_next;
`ifdef PIPO_TX_PARITY_EN
    logic          par_reg, par_next;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sh_reg  <= '0;
            cnt     <= '0;
`ifdef PIPO_TX_PARITY_EN
            par_reg <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            sh_reg  <= sh_next;
            cnt     <= cnt_next;
`ifdef PIPO_TX_PARITY_EN
            par_reg <= par_next;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        sh_next    = sh_reg;
        cnt_next   = cnt;
`ifdef PIPO_TX_PARITY_EN
        par_next   = par_reg;
`endif
        s_out      = 1'b0;
        s_valid    = 1'b0;
        busy       = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    sh_next    = din;
                    cnt_next   = '0;
`ifdef PIPO_TX_PARITY_EN
                    par_next   = ^din;
`endif
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                s_out    = sh_reg[0];
                s_valid  = 1'b1;
                busy     = 1'b1;
                // Zero-fill from the top so the register is clean once the
                // frame has drained.
                sh_next  = {1'b0, sh_reg[N-1:1]};
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) begin
`ifdef PIPO_TX_PARITY_EN
                    state_next = PAR;
`else
                    done       = 1'b1;
                    state_next = IDLE;
`endif
                end
            end

`ifdef PIPO_TX_PARITY_EN
            PAR: begin
                s_out      = par_reg;
                s_valid    = 1'b1;
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_tx
//
// Self-checking bench for piso_shift_tx (N = 8). A queue-based reference model
// holds the bits still to be sent for the frame in flight; every cycle the DUT
// outputs are compared against it. Directed scenarios (single frame, ignored
// start, back-to-back, loopback, resets) are followed by a random phase.
// Compile with +define+PIPO_TX_PARITY_EN to check the parity build.
// -----------------------------------------------------------------------------
module tb_piso_shift_tx;

    localparam int N = 8;
`ifdef PIPO_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = N + PAR;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] din = '0;
    logic         s_out, s_valid, busy, ready, done;

    int errors = 0;
    int checks = 0;

    piso_shift_tx #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .din     (din),
        .s_out   (s_out),
        .s_valid (s_valid),
        .busy    (busy),
        .ready   (ready),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bits of the frame still to be shown, front = current bit.
    // Empty queue means IDLE.
    logic model_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_q.delete();
        end else if (model_q.size() == 0) begin
            if (start) begin
                for (int i = 0; i < N; i++) model_q.push_back(din[i]);
                if (PAR == 1) model_q.push_back(^din);
            end
        end else begin
            void'(model_q.pop_front());
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic m_busy;
        m_busy = (model_q.size() != 0);
        check("s_out",   s_out,   m_busy ? model_q[0] : 1'b0);
        check("s_valid", s_valid, m_busy);
        check("busy",    busy,    m_busy);
        check("ready",   ready,   !m_busy);
        check("done",    done,    model_q.size() == 1);
    end

    // Loopback receiver: right shift on clk while s_valid.
    logic [N-1:0] r_reg;
    always @(posedge clk or posedge reset) begin
        if (reset)        r_reg <= '0;
        else if (s_valid) r_reg <= {s_out, r_reg[N-1:1]};
    end

    // Collects one frame starting at the current negedge. Returns at the first
    // negedge without s_valid after the frame. Optionally pokes start/din with
    // 0xFF while bits 2..5 are on the line.
    task automatic collect(input bit poke, output logic [N:0] bits,
                           output int nvalid, output int done_at);
        bits = '0;
        nvalid = 0;
        done_at = -1;
        for (int c = 0; c < 40; c++) begin
            if (s_valid) begin
                bits[nvalid] = s_out;
                if (done) done_at = nvalid;
                if (poke) begin
                    start = (nvalid >= 2 && nvalid <= 5);
                    din   = (nvalid >= 2 && nvalid <= 5) ? 8'hFF : 8'h3C;
                end
                nvalid++;
            end else if (nvalid > 0) begin
                return;
            end
            @(negedge clk);
        end
        check("frame_timeout", 1, 0);
    endtask

    function automatic logic [N:0] frame_of(input logic [N-1:0] w);
        return (PAR == 1) ? {^w, w} : {1'b0, w};
    endfunction

    task automatic send_and_check(input string tag, input logic [N-1:0] w);
        logic [N:0] bits;
        int nv, da;
        @(negedge clk);
        start = 1'b1;
        din   = w;
        @(negedge clk);
        start = 1'b0;
        din   = $urandom;
        collect(1'b0, bits, nv, da);
        check({tag, "_bits"},  bits, frame_of(w));
        check({tag, "_len"},   nv, FL);
        check({tag, "_done"},  da, FL - 1);
        check({tag, "_ready"}, ready, 1);
    endtask

    initial begin
        logic [N:0] bits;
        int nv, da;

        // Reset values while reset is held.
        #1;
        check("rst_s_out", s_out, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single frame.
        send_and_check("a5", 8'hA5);

        // Ignored start during bits 2..5.
        @(negedge clk);
        start = 1'b1;
        din   = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        collect(1'b1, bits, nv, da);
        start = 1'b0;
        check("ign_bits", bits, frame_of(8'h3C));
        check("ign_len", nv, FL);
        @(negedge clk);
        check("ign_no_second", busy, 0);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        din   = 8'h01;
        @(negedge clk);
        din   = 8'h80;
        collect(1'b0, bits, nv, da);
        check("b2b_first", bits, frame_of(8'h01));
        check("b2b_gap_idle", ready, 1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_gap_one", s_valid, 1);
        collect(1'b0, bits, nv, da);
        check("b2b_second", bits, frame_of(8'h80));
        check("b2b_second_len", nv, FL);

        // Loopback into the right-shift receiver.
        send_and_check("lb", 8'h5A);
        check("loopback", r_reg, (PAR == 1) ? {^8'h5A, 8'h2D} : 8'h5A);

        // Parity-specific word.
        send_and_check("w07", 8'h07);

        // Asynchronous reset mid-frame after 3 bits.
        @(negedge clk);
        start = 1'b1;
        din   = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_s_out", s_out, 0);
        check("arst_s_valid", s_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("arst_idle", s_valid, 0);
        end

        // Random phase, with occasional short asynchronous resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            din   = $urandom;
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (FL + 2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
